// File: rtl/rob_commit_controller_pkg.sv
// Shared LC-3b types for the commit path: opcodes, commit classes and the
// retirement FSM states, plus the opcode-to-class decode used by dispatch too.
package rob_commit_controller_pkg;

  // Encodings follow the LC-3b ISA opcode field, IR[15:12].
  typedef enum logic [3:0] {
    OpBr   = 4'b0000,
    OpAdd  = 4'b0001,
    OpLdb  = 4'b0010,
    OpStb  = 4'b0011,
    OpJsr  = 4'b0100,
    OpAnd  = 4'b0101,
    OpLdr  = 4'b0110,
    OpStr  = 4'b0111,
    OpRti  = 4'b1000,
    OpNot  = 4'b1001,
    OpLdi  = 4'b1010,
    OpSti  = 4'b1011,
    OpJmp  = 4'b1100,
    OpShf  = 4'b1101,
    OpLea  = 4'b1110,
    OpTrap = 4'b1111
  } lc3b_opcode;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    ClsWrite,
    ClsStore,
    ClsBranch,
    ClsNop
  } lc3b_commit_class;

  typedef enum logic [1:0] {
    StRun,
    StStoreWait,
    StFlush
  } rob_commit_state_t;

  function automatic lc3b_commit_class classify(input lc3b_opcode op);
    lc3b_commit_class cls;
    cls = ClsNop;
    unique case (op)
      OpAdd, OpAnd, OpNot, OpLea,
      OpLdr, OpLdb, OpLdi, OpShf,
      OpJsr, OpTrap:               cls = ClsWrite;
      OpStr, OpStb, OpSti:         cls = ClsStore;
      OpBr:                        cls = ClsBranch;
      OpJmp, OpRti:                cls = ClsNop;
      default:                     cls = ClsNop;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/rob_commit_controller_classifier.sv
// Combinational opcode -> commit class decode; shared with dispatch so both
// sides agree on which ops write registers, store, or branch.
module rob_commit_controller_classifier
  import rob_commit_controller_pkg::*;
(
  input  lc3b_opcode       opcode_i,
  output lc3b_commit_class class_o
);

  always_comb begin
    class_o = classify(opcode_i);
  end

endmodule

// File: rtl/rob_commit_controller.sv
// In-order ROB retirement: register writeback, store commit handshake and
// branch resolution with flush/redirect on mispredict.
module rob_commit_controller
  import rob_commit_controller_pkg::*;
#(
  parameter int unsigned data_width = 16,
  parameter int unsigned tag_width  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rob_empty,
  input  logic                  rob_valid,
  input  lc3b_opcode            rob_inst,
  input  lc3b_reg               rob_dest,
  input  logic [data_width-1:0] rob_value,
  input  logic                  rob_predict,
  output logic                  rob_re,
  output logic                  rob_flush,
  output logic                  rf_we,
  output lc3b_reg               rf_dest,
  output logic [data_width-1:0] rf_value,
  output logic [tag_width-1:0]  rf_tag,
  output logic                  mem_commit_req,
  input  logic                  mem_commit_ack,
  output logic                  redirect_valid,
  output logic [data_width-1:0] redirect_pc,
  output logic [15:0]           retire_count,
  output logic [15:0]           mispredict_count
);

  rob_commit_state_t     state_q, state_d;
  logic [tag_width-1:0]  head_tag_q, head_tag_d;
  logic [15:0]           retire_count_q, retire_count_d;
  logic [15:0]           mispredict_count_q, mispredict_count_d;
  logic [data_width-1:0] redirect_pc_q, redirect_pc_d;

  lc3b_commit_class head_class;
  logic             head_ready;

  rob_commit_controller_classifier u_classifier (
    .opcode_i (rob_inst),
    .class_o  (head_class)
  );

  // Outputs are forced low while reset is held, even with a ready head.
  assign head_ready = !reset && !rob_empty && rob_valid;

  always_comb begin
    state_d            = state_q;
    head_tag_d         = head_tag_q;
    retire_count_d     = retire_count_q;
    mispredict_count_d = mispredict_count_q;
    redirect_pc_d      = redirect_pc_q;
    rob_re             = 1'b0;
    rf_we              = 1'b0;
    mem_commit_req     = 1'b0;

    unique case (state_q)
      StRun: begin
        if (head_ready) begin
          unique case (head_class)
            ClsWrite: begin
              rob_re = 1'b1;
              rf_we  = 1'b1;
            end
            ClsNop: begin
              rob_re = 1'b1;
            end
            ClsBranch: begin
              rob_re = 1'b1;
              if (rob_value[0] != rob_predict) begin
                redirect_pc_d      = {rob_value[data_width-1:1], 1'b0};
                mispredict_count_d = mispredict_count_q + 16'd1;
                state_d            = StFlush;
              end
            end
            ClsStore: begin
              // Ack in this cycle is ignored; pop only once in StStoreWait.
              mem_commit_req = 1'b1;
              state_d        = StStoreWait;
            end
            default: ;
          endcase
        end
      end
      StStoreWait: begin
        if (!reset) begin
          mem_commit_req = 1'b1;
          if (mem_commit_ack && !rob_empty) begin
            rob_re  = 1'b1;
            state_d = StRun;
          end
        end
      end
      StFlush: begin
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase

    if (rob_re) begin
      head_tag_d     = head_tag_q + tag_width'(1);
      retire_count_d = retire_count_q + 16'd1;
    end
    // The ROB is emptied by the flush, so allocation restarts at tag 0.
    if (state_q == StFlush) begin
      head_tag_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= StRun;
      head_tag_q         <= '0;
      retire_count_q     <= '0;
      mispredict_count_q <= '0;
      redirect_pc_q      <= '0;
    end else begin
      state_q            <= state_d;
      head_tag_q         <= head_tag_d;
      retire_count_q     <= retire_count_d;
      mispredict_count_q <= mispredict_count_d;
      redirect_pc_q      <= redirect_pc_d;
    end
  end

  assign rf_dest          = rf_we ? rob_dest : '0;
  assign rf_value         = rf_we ? rob_value : '0;
  assign rf_tag           = head_tag_q;
  assign rob_flush        = !reset && (state_q == StFlush);
  assign redirect_valid   = !reset && (state_q == StFlush);
  assign redirect_pc      = redirect_pc_q;
  assign retire_count     = retire_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: doc/rob_commit_controller.md
Name: rob_commit_controller

Overview:
- Retirement sequencer for the reorder buffer in the Tomasulo LC-3b datapath.
- Each cycle it inspects the ROB head entry and, once that entry is complete, retires it in program order:
  - register-writing ops write the architectural register file;
  - stores get a one-at-a-time commit handshake with the memory unit;
  - branches are checked against their prediction, and a mispredict flushes the ROB and redirects fetch.
- It keeps the head tag so that register alias entries can be cleared, and it keeps retire and mispredict counters for performance statistics.

Parameters:
- data_width, 16, width of ROB value field, PC and register data
- tag_width, 3, ROB tag width; ROB depth = 2**tag_width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rob_empty  in  1  ROB holds no entries
- rob_valid  in  1  head entry has its result (valid_out)
- rob_inst  in  lc3b_opcode  head opcode
- rob_dest  in  lc3b_reg  head destination register
- rob_value  in  data_width  head result; for BR: bit0 = actual taken, {value[15:1],0} = correct next PC
- rob_predict  in  1  head predicted-taken bit
- rob_re  out  1  pop ROB head this cycle
- rob_flush  out  1  flush the ROB
- rf_we  out  1  architectural register write
- rf_dest  out  lc3b_reg  register to write
- rf_value  out  data_width  data to write
- rf_tag  out  tag_width  ROB tag being retired; the RAT clears the alias if it matches
- mem_commit_req  out  1  request that the memory unit perform the head store
- mem_commit_ack  in  1  store performed; single-cycle pulse
- redirect_valid  out  1  fetch redirect, one-cycle pulse
- redirect_pc  out  data_width  correct next PC
- retire_count  out  16  number of retired instructions, wraps
- mispredict_count  out  16  number of branch mispredicts, wraps

Behaviour:
- Reset: every output is 0, state = RUN, head_tag = 0, both counters = 0. Reset during STORE_WAIT or FLUSH drops the request or flush immediately; the next cycle is RUN.
- Opcode classes:
  - WRITE = add, and, not, lea, ldr, ldb, ldi, shf, jsr, trap
  - STORE = str, stb, sti
  - BRANCH = br
  - NOP = jmp, rti
- Commit condition: state = RUN and !rob_empty and rob_valid. Outputs are combinational from the head (Mealy); the pop takes effect at the clock edge that ends the cycle.
- RUN, head not committable: all strobes = 0, hold.
- RUN, WRITE: rob_re = rf_we = 1; rf_dest = rob_dest, rf_value = rob_value, rf_tag = head_tag.
- RUN, NOP: rob_re = 1, rf_we = 0.
- RUN, BRANCH, correct prediction (rob_value[0] == rob_predict): rob_re = 1.
- RUN, BRANCH, mispredict:
  - rob_re = 1 this cycle;
  - register {rob_value[15:1],1'b0} into redirect_pc;
  - mispredict_count increments;
  - next state = FLUSH.
- RUN, STORE: mem_commit_req = 1, next state = STORE_WAIT. No pop yet.
- STORE_WAIT:
  - mem_commit_req stays 1 while waiting.
  - On mem_commit_ack: rob_re = 1, mem_commit_req = 1 that cycle, next state = RUN.
  - An ack in the same cycle as the RUN-state request is ignored; an ack is only honoured in STORE_WAIT.
- FLUSH (exactly one cycle):
  - rob_flush = 1, redirect_valid = 1, redirect_pc = registered value;
  - head_tag resets to 0, next state = RUN;
  - no commit happens during FLUSH.
- head_tag increments mod 2**tag_width on every rob_re. It wraps 7→0 at the default parameters.
- retire_count increments on every rob_re, including the mispredicted branch. Both counters wrap at 0xFFFF→0.
- At most one retirement per cycle.
- rob_re is never asserted when rob_empty = 1.
- Only one of rf_we, mem_commit_req-with-ack, or a branch check is effective in any cycle.

Decomposition:
- lc3b_types gains:
  - typedef lc3b_commit_class (WRITE, STORE, BRANCH, NOP);
  - function classify(lc3b_opcode) returning lc3b_commit_class;
  - typedef rob_commit_state_t (RUN, STORE_WAIT, FLUSH).
- One natural sub-module: commit_classifier, the combinational opcode→class decode. It is reused by dispatch for its ROB-allocation decisions.
- The FSM, head_tag counter and stat counters live in the top module.

Test Plan:
- ADD in head: rob_inst = add, rob_dest = R3, rob_value = 0x1234, rob_valid = 1, head_tag = 0 → in the same cycle rob_re = 1, rf_we = 1, rf_dest = R3, rf_value = 0x1234, rf_tag = 0. Next cycle head_tag = 1 and retire_count = 1.
- Head not ready: rob_empty = 0, rob_valid = 0 for 5 cycles → rob_re = rf_we = 0 throughout. Then rob_valid = 1 → commit occurs in that cycle.
- STR with ack after 3 cycles:
  - mem_commit_req = 1 from cycle 0, rob_re = 0 in cycles 0–2;
  - ack in cycle 3 → rob_re = 1, then state RUN.
  - Reset asserted in cycle 2 of a second store → mem_commit_req = 0 in the next cycle.
- Branch, correct prediction: rob_predict = 1, rob_value = 0x3001 → rob_re = 1, no flush, mispredict_count stays 0.
- Branch mispredict: rob_predict = 0, rob_value = 0x4021 →
  - cycle N: rob_re = 1;
  - cycle N+1: rob_flush = 1, redirect_valid = 1, redirect_pc = 0x4020, mispredict_count = 1;
  - cycle N+2: head_tag = 0, no strobes active.
- Wrap: retire 9 consecutive ADDs → rf_tag sequence 0..7,0 and retire_count = 9.
